// File: rtl/otp_pkg.sv
// Shared definitions for the OTP cipher datapath: transmitter FSM encoding,
// header byte layout and the pad index width also used by the encryptor.
package otp_pkg;

  localparam int PAD_IDX_W = 3;
  localparam int TAG_W     = 4;
  localparam int DATA_W    = 8;
  localparam int ENTRY_W   = PAD_IDX_W + DATA_W;

  localparam logic [TAG_W-1:0] HDR_TAG_DEFAULT = 4'hA;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  // Header byte: tag nibble, a reserved zero bit, then the pad index.
  function automatic logic [DATA_W-1:0] make_header(input logic [TAG_W-1:0] tag,
                                                    input logic [PAD_IDX_W-1:0] idx);
    return {tag, 1'b0, idx};
  endfunction

endpackage

// File: rtl/otp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding {index, data} entries.
// Pointers wrap modulo DEPTH; occupancy is kept in its own counter.
import otp_pkg::*;

module otp_sync_fifo #(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  // A write while full is dropped even if a read frees a slot this cycle.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/otp_cipher_uart_tx.sv
// Buffers ciphertext bytes and sends each as a UART record: header {tag,0,index}
// then the data byte. Define OTP_TX_PARITY_EN to append an even-parity bit per byte.
import otp_pkg::*;

module otp_cipher_uart_tx #(
  parameter int               CLKS_PER_BIT = 16,
  parameter int               FIFO_DEPTH   = 8,
  parameter logic [TAG_W-1:0] HDR_TAG      = HDR_TAG_DEFAULT,
  localparam int              CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [PAD_IDX_W-1:0] in_index,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [ENTRY_W-1:0]   fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push_ok;
  logic [PAD_IDX_W-1:0] rd_index;
  logic [DATA_W-1:0]    rd_byte;

  tx_state_t            state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [2:0]           bit_reg, bit_next;
  logic [DATA_W-1:0]    shift_reg, shift_next;
  logic [DATA_W-1:0]    hold_reg, hold_next;
  logic                 sel_reg, sel_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 overflow_reg, overflow_next;
  logic                 baud_done;
`ifdef OTP_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  otp_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data ({in_index, in_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_index  = fifo_rd_data[ENTRY_W-1 -: PAD_IDX_W];
  assign rd_byte   = fifo_rd_data[DATA_W-1:0];
  assign in_ready  = ~fifo_full;
  assign push_ok   = in_valid & ~fifo_full;
  assign baud_done = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      hold_reg     <= '0;
      sel_reg      <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef OTP_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      hold_reg     <= hold_next;
      sel_reg      <= sel_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      overflow_reg <= overflow_next;
`ifdef OTP_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    hold_next  = hold_reg;
    sel_next   = sel_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = make_header(HDR_TAG, rd_index);
          hold_next  = rd_byte;
          sel_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[DATA_W-1:1]};
          bit_next   = bit_reg + 3'd1;
`ifdef OTP_TX_PARITY_EN
          if (bit_reg == 3'd7) state_next = PARITY;
`else
          if (bit_reg == 3'd7) state_next = STOP;
`endif
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`ifdef OTP_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Header just finished: the data byte of the same record follows.
          if (!sel_reg) begin
            shift_next = hold_reg;
            sel_next   = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef OTP_TX_PARITY_EN
  always_comb begin
    parity_next = parity_reg;
    if (state_next == START && state_reg != START) parity_next = ^shift_next;
  end
`endif

  // Line level follows the current state, so tx trails the state by one cycle.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
`ifdef OTP_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // Occupancy after this edge is non-zero on a push, or if more than the popped entry remains.
  assign busy_next     = (state_next != IDLE) || push_ok || (fifo_count > CNT_W'(pop));
  assign overflow_next = overflow_reg | (in_valid & fifo_full);

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_otp_cipher_uart_tx.sv
// Scoreboarded bench: stimulus queues expected {index,data} records, a UART
// receiver process decodes tx and compares each record it sees.
module tb_otp_cipher_uart_tx;

  localparam int CPB = 4;
`ifdef OTP_TX_PARITY_EN
  localparam int REC = 22 * CPB;
`else
  localparam int REC = 20 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [2:0] in_index = '0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit exp_ovf = 0;
  bit mon_en = 1;
  logic [10:0] exp_q[$];
  int rec_starts[$];

  otp_cipher_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_index   (in_index),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one push attempt across a rising edge; acceptance is known from in_ready before the edge.
  task automatic drive(input logic [7:0] d, input logic [2:0] idx, input bit enq, output bit acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_index = idx;
    acc = in_ready;
    if (acc && enq) exp_q.push_back({idx, d});
    if (!acc) exp_ovf = 1;
    @(posedge clk);
  endtask

  task automatic release_bus();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ovf = 0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 30000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    check("drain_timeout", {31'd0, done}, 32'd1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  // UART receiver model: samples the middle of every bit period.
  logic [7:0] mon_byte;
  logic [7:0] mon_hdr;
  logic       mon_ok;
  int         mon_phase = 0;
  int         mon_start;
  logic [10:0] mon_exp;

  always begin
    @(negedge clk);
    if (mon_en && !rst && tx === 1'b0) begin
      mon_start = cyc;
      repeat (CPB / 2) @(negedge clk);
      mon_ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_byte[i] = tx;
      end
`ifdef OTP_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      check("parity_bit", {31'd0, tx}, {31'd0, ^mon_byte});
`endif
      repeat (CPB) @(negedge clk);
      mon_ok = mon_ok && (tx === 1'b1);
      check("frame_start_stop", {31'd0, mon_ok}, 32'd1);
      if (mon_phase == 0) begin
        mon_hdr = mon_byte;
        rec_starts.push_back(mon_start);
        mon_phase = 1;
      end else begin
        mon_phase = 0;
        $display("record: header=%02h data=%02h", mon_hdr, mon_byte);
        if (exp_q.size() == 0) begin
          check("unexpected_record", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("header_byte", {24'd0, mon_hdr}, {24'd0, 8'hA0 | {5'd0, mon_exp[10:8]}});
          check("data_byte", {24'd0, mon_byte}, {24'd0, mon_exp[7:0]});
        end
      end
    end
  end

  initial begin
    bit acc;
    int edges;
    logic prev_tx;
    bit seen;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single record with latency and duration checks
    drive(8'h5A, 3'd3, 1, acc);
    release_bus();
    check("single_count_n1", {28'd0, fifo_count}, 32'd1);
    check("single_tx_n1", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("single_count_pop", {28'd0, fifo_count}, 32'd0);
    check("single_tx_n2", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("single_tx_low", {31'd0, tx}, 32'd0);
    repeat (REC - 2) @(negedge clk);
    check("single_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_busy_fall", {31'd0, busy}, 32'd0);
    check("single_overflow", {31'd0, overflow}, 32'd0);
    wait_drain();

    // Simultaneous push and pop keeps the count, next record one idle cycle later
    rec_starts.delete();
    drive(8'h3C, 3'd5, 1, acc);
    drive(8'hC3, 3'd2, 1, acc);
    release_bus();
    check("simul_count", {28'd0, fifo_count}, 32'd1);
    wait_drain();
    check("simul_records", rec_starts.size(), 2);
    if (rec_starts.size() == 2)
      check("simul_gap", rec_starts[1] - rec_starts[0], REC + 1);

    // Fill: nine accepted while draining, tenth rejected
    for (int i = 0; i < 10; i++) begin
      drive(8'(i), 3'(i), 1, acc);
      check("fill_accept", {31'd0, acc}, (i < 9) ? 32'd1 : 32'd0);
    end
    release_bus();
    check("fill_count", {28'd0, fifo_count}, 32'd8);
    check("fill_overflow", {31'd0, overflow}, 32'd1);
    wait_drain();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    pulse_reset();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Reset in the middle of header bit 3
    mon_en = 0;
    drive(8'h96, 3'd6, 0, acc);
    release_bus();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (tx == 1'b0) seen = 1;
      else @(negedge clk);
    end
    check("midrst_start_seen", {31'd0, seen}, 32'd1);
    repeat ((1 + 3) * CPB + 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ovf = 0;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_count", {28'd0, fifo_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    edges = 0;
    prev_tx = tx;
    for (int i = 0; i < 3 * REC; i++) begin
      @(negedge clk);
      if (tx !== prev_tx) edges++;
      prev_tx = tx;
    end
    check("midrst_quiet", edges, 0);
    mon_phase = 0;
    mon_en = 1;

    // Randomized traffic with bursts and gaps
    for (int t = 0; t < 40; t++) begin
      drive(8'($urandom), 3'($urandom), 1, acc);
      if ($urandom_range(0, 3) != 0) begin
        release_bus();
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    end
    release_bus();
    wait_drain();
    check("rand_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
